// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the serial system bus arbiter and its master/slave ports.
package bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_MASTERS_DEF = 2;

  function automatic int mid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int MID_WIDTH_DEF = mid_width(NUM_MASTERS_DEF);

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after i_start, wrapping.
module bus_arbiter_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int MID_WIDTH   = mid_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MID_WIDTH-1:0]   i_start,
  output logic                   o_valid,
  output logic [MID_WIDTH-1:0]   o_idx
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      w_cand = (int'(i_start) + i) % NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if ((j == w_cand) && i_req[j]) begin
          o_valid = 1'b1;
          o_idx   = MID_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central round-robin arbiter for the serial system bus with one outstanding slave split.
//
// state    | meaning
// ARB_IDLE | no grant; resume a ready split, else grant a new eligible request
// ARB_BUSY | one master (r_msel) owns the bus until it drops mbreq or is split
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int MID_WIDTH   = mid_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] i_mbreq,
  output logic [NUM_MASTERS-1:0] o_mbgrant,
  output logic [NUM_MASTERS-1:0] o_msplit,
  output logic [MID_WIDTH-1:0]   o_msel,
  output logic                   o_bus_busy,
  input  logic                   i_ssplit,
  input  logic                   i_split_done,
  output logic                   o_split_err
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [NUM_MASTERS-1:0] r_mbgrant, w_mbgrant_nxt;
  logic [NUM_MASTERS-1:0] r_msplit, w_msplit_nxt;
  logic [MID_WIDTH-1:0]   r_msel, w_msel_nxt;
  logic [MID_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [MID_WIDTH-1:0]   r_split_id, w_split_id_nxt;
  logic                   r_split_valid, w_split_valid_nxt;
  logic                   r_split_ready, w_split_ready_nxt;
  logic                   r_split_err, w_split_err_nxt;

  logic [NUM_MASTERS-1:0] w_req_elig;
  logic                   w_pick_valid;
  logic [MID_WIDTH-1:0]   w_pick_idx;

  assign w_req_elig = i_mbreq & ~r_msplit;

  bus_arbiter_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MID_WIDTH   (MID_WIDTH)
  ) u_picker (
    .i_req   (w_req_elig),
    .i_start (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ARB_IDLE;
      r_mbgrant     <= '0;
      r_msplit      <= '0;
      r_msel        <= '0;
      r_rr_ptr      <= '0;
      r_split_id    <= '0;
      r_split_valid <= 1'b0;
      r_split_ready <= 1'b0;
      r_split_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mbgrant     <= w_mbgrant_nxt;
      r_msplit      <= w_msplit_nxt;
      r_msel        <= w_msel_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_split_id    <= w_split_id_nxt;
      r_split_valid <= w_split_valid_nxt;
      r_split_ready <= w_split_ready_nxt;
      r_split_err   <= w_split_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mbgrant_nxt     = r_mbgrant;
    w_msplit_nxt      = r_msplit;
    w_msel_nxt        = r_msel;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_split_id_nxt    = r_split_id;
    w_split_valid_nxt = r_split_valid;
    // split_done is remembered until the bus is idle enough to resume
    w_split_ready_nxt = r_split_ready | (i_split_done & r_split_valid);
    w_split_err_nxt   = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (r_split_valid && r_split_ready) begin
          w_msplit_nxt[r_split_id] = 1'b0;
          w_split_valid_nxt        = 1'b0;
          w_split_ready_nxt        = 1'b0;
          if (i_mbreq[r_split_id]) begin
            w_mbgrant_nxt             = '0;
            w_mbgrant_nxt[r_split_id] = 1'b1;
            w_msel_nxt                = r_split_id;
            w_state_nxt               = ARB_BUSY;
          end
        end else if (w_pick_valid) begin
          w_mbgrant_nxt             = '0;
          w_mbgrant_nxt[w_pick_idx] = 1'b1;
          w_msel_nxt                = w_pick_idx;
          w_rr_ptr_nxt = (w_pick_idx == MID_WIDTH'(NUM_MASTERS - 1)) ?
                         '0 : w_pick_idx + MID_WIDTH'(1);
          w_state_nxt               = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A dropped request wins over a same-cycle split from the slave.
        if (!i_mbreq[r_msel]) begin
          w_mbgrant_nxt = '0;
          w_state_nxt   = ARB_IDLE;
        end else if (i_ssplit) begin
          if (!r_split_valid) begin
            w_msplit_nxt[r_msel]  = 1'b1;
            w_mbgrant_nxt         = '0;
            w_split_id_nxt        = r_msel;
            w_split_valid_nxt     = 1'b1;
            w_state_nxt           = ARB_IDLE;
          end else begin
            w_split_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign o_mbgrant   = r_mbgrant;
  assign o_msplit    = r_msplit;
  assign o_msel      = r_msel;
  assign o_bus_busy  = |r_mbgrant;
  assign o_split_err = r_split_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle expectations queued at drive time, checked after the edge.
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int MW = 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NM-1:0] mbreq = '0;
  logic [NM-1:0] mbgrant;
  logic [NM-1:0] msplit;
  logic [MW-1:0] msel;
  logic          bus_busy;
  logic          ssplit = 1'b0;
  logic          split_done = 1'b0;
  logic          split_err;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(NM), .MID_WIDTH(MW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_mbreq      (mbreq),
    .o_mbgrant    (mbgrant),
    .o_msplit     (msplit),
    .o_msel       (msel),
    .o_bus_busy   (bus_busy),
    .i_ssplit     (ssplit),
    .i_split_done (split_done),
    .o_split_err  (split_err)
  );

  typedef struct {
    logic [NM-1:0] grant;
    logic [NM-1:0] split;
    logic [MW-1:0] sel;
    logic          busy;
    logic          err;
    string         tag;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [MW-1:0] exp_owner = '0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next edge, then check.
  task automatic step(input logic [NM-1:0] req, input logic ss, input logic sd,
                      input logic [NM-1:0] eg, input logic [NM-1:0] es, input logic ee,
                      input string tag);
    exp_t e;
    exp_t got;
    mbreq      = req;
    ssplit     = ss;
    split_done = sd;
    if (!rstn) exp_owner = '0;
    else if (eg == 2'b01) exp_owner = MW'(0);
    else if (eg == 2'b10) exp_owner = MW'(1);
    e.grant = eg;
    e.split = es;
    e.sel   = exp_owner;
    e.busy  = |eg;
    e.err   = ee;
    e.tag   = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({got.tag, ".grant"}, 32'(mbgrant), 32'(got.grant));
    check({got.tag, ".msplit"}, 32'(msplit), 32'(got.split));
    check({got.tag, ".msel"}, 32'(msel), 32'(got.sel));
    check({got.tag, ".busy"}, 32'(bus_busy), 32'(got.busy));
    check({got.tag, ".err"}, 32'(split_err), 32'(got.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // T1 reset with requests asserted
    rstn = 1'b0;
    step(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t1_rst0");
    step(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t1_rst1");
    rstn = 1'b1;

    // T2 single request latency and release
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t2_idle");
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t2_grant");
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t2_hold");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t2_drop");

    // T3 round-robin; pointer sits at M1 after T2
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, "t3_m1");
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, "t3_m1_hold");
    step(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t3_gap1");
    step(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t3_m0");
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t3_m0_hold");
    step(2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t3_gap2");
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, "t3_m1_again");
    step(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t3_gap3");

    // T4 split of M0, M1 runs, resume after M1 finishes
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t4_m0");
    step(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t4_m0_hold");
    step(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "t4_split");
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, "t4_m1");
    step(2'b11, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, "t4_done_busy");
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, "t4_wait");
    step(2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, "t4_m1_drop");
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t4_resume");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t4_end");

    // T5 second split while one is outstanding
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t5_m0");
    step(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "t5_split");
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, "t5_m1");
    step(2'b11, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, "t5_err");
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, "t5_err_clr");

    // T6 drop beats split (also beats split_err), then clear the pending split
    step(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "t6_drop_vs_err");
    step(2'b01, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, "t6_parked_masked");
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t6_resume");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t6_end");
    step(2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, "t6_m1");
    step(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "t6_drop_vs_split");
    step(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "t6_idle_split");

    // T6 parked master abandons, then split_done
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t6b_m0");
    step(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "t6b_split");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, "t6b_abandon");
    step(2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, "t6b_done");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t6b_cleared");
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "t6b_stay_idle");
    step(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, "t6b_new_grant");
    step(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "t6b_split_again");

    // Reset in the middle of a transaction
    step(2'b11, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, "rst_m1");
    rstn = 1'b0;
    step(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "rst_mid");
    rstn = 1'b1;
    step(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "rst_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
